uart_rx_fifo: RTL and testbench

//  Receive buffer between uart_rx and the io register block: drains bytes from uart_rx as soon as

---
 rtl/uart_rx_fifo.sv | 107 ++++++++++
 tb/tb_uart_rx_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive buffer between uart_rx and the CPU read path: FWFT byte FIFO with a 3-state ingress
// handshake, count/level/sticky-overflow status. Optional watermark via UART_RX_FIFO_WMARK_EN.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned WMARK = 12
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [7:0]    rx_data,
   input  logic          rx_ready,
   output logic          rx_ack,
   input  logic          rd_strobe,
   output logic [7:0]    rd_data,
   output logic          not_empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overflow,
   input  logic          ovf_clr,
   output logic          wmark
);

   if (DEPTH != (32'd1 << AW) || DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of two in 2..256 equal to 2**AW");
   end
   if (WMARK < 1 || WMARK > DEPTH) begin : g_bad_wmark
      $error("uart_rx_fifo: WMARK must be in 1..DEPTH");
   end

   typedef enum logic [1:0] {StIdle, StAck, StHold} state_e;

   state_e        state_q;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q;
   logic          rx_ack_q, overflow_q;
   logic          take, push, pop, drop;

   assign not_empty = (count_q != '0);
   assign full      = (count_q == (AW+1)'(DEPTH));
   assign pop       = rd_strobe && not_empty;
   assign take      = (state_q == StIdle) && rx_ready;
   // A full FIFO still accepts the byte when a pop frees the head in the same cycle.
   assign push      = take && (!full || pop);
   assign drop      = take && !push;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         rx_ack_q   <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (rx_ready) begin
                  state_q  <= StAck;
                  rx_ack_q <= 1'b1;
               end
            end
            StAck: begin
               state_q  <= StHold;
               rx_ack_q <= 1'b0;
            end
            StHold:  state_q <= StIdle;
            default: begin
               state_q  <= StIdle;
               rx_ack_q <= 1'b0;
            end
         endcase

         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;

         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;

         if (drop)         overflow_q <= 1'b1;
         else if (ovf_clr) overflow_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr_q] <= rx_data;
   end

   assign rd_data  = mem[rptr_q];
   assign rx_ack   = rx_ack_q;
   assign count    = count_q;
   assign overflow = overflow_q;

`ifdef UART_RX_FIFO_WMARK_EN
   logic wmark_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) wmark_q <= 1'b0;
      else         wmark_q <= (count_q >= (AW+1)'(WMARK));
   end

   assign wmark = wmark_q;
`else
   assign wmark = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed and random traffic against a queue-based model.
module tb_uart_rx_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned WMARK = 12;
`ifdef UART_RX_FIFO_WMARK_EN
   localparam bit WmEn = 1'b1;
`else
   localparam bit WmEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          rx_ack;
   logic          rd_strobe;
   logic [7:0]    rd_data;
   logic          not_empty;
   logic          full;
   logic [AW:0]   count;
   logic          overflow;
   logic          ovf_clr;
   logic          wmark;

   uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .WMARK(WMARK)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .rx_ack    (rx_ack),
      .rd_strobe (rd_strobe),
      .rd_data   (rd_data),
      .not_empty (not_empty),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr),
      .wmark     (wmark)
   );

   always #5 clk = ~clk;

   int         nvec = 0;
   int         nerr = 0;
   int         acks = 0;
   logic [7:0] q[$];
   bit         ovf_m = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_status(input bit exp_wm);
      chk("count", 32'(count), q.size());
      chk("not_empty", 32'(not_empty), 32'(q.size() != 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      chk("wmark", 32'(wmark), 32'(exp_wm));
      if (q.size() != 0) chk("head", 32'(rd_data), 32'(q[0]));
   endtask

   // uart_rx model: hold ready until the ack strobe, then drop it; optional pop/clear alongside.
   task automatic send(input logic [7:0] b, input bit pop, input bit clr);
      int  sz;
      bit  did_pop;
      int  n;
      sz      = q.size();
      did_pop = pop && (sz > 0);
      if (did_pop) begin
         chk("head_at_pop", 32'(rd_data), 32'(q[0]));
         q.delete(0);
      end
      if (sz < DEPTH || did_pop) q.push_back(b);
      else                       ovf_m = 1'b1;
      if (!(sz >= DEPTH && !did_pop) && clr) ovf_m = 1'b0;
      rx_data   = b;
      rx_ready  = 1'b1;
      rd_strobe = pop;
      ovf_clr   = clr;
      step();
      rd_strobe = 1'b0;
      ovf_clr   = 1'b0;
      n = 1;
      while (!rx_ack && n < 8) begin
         step();
         n++;
      end
      chk("ack_latency", n, 1);
      if (rx_ack) acks++;
      rx_ready = 1'b0;
      step();
      chk("ack_one_cycle", 32'(rx_ack), 0);
      step();
      chk_status(WmEn && q.size() >= WMARK);
   endtask

   task automatic pop1();
      int pre;
      pre = q.size();
      if (pre > 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
      rd_strobe = 1'b1;
      step();
      rd_strobe = 1'b0;
      if (pre > 0) q.delete(0);
      chk_status(WmEn && pre >= WMARK);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (q.size() > 0 && guard < 2 * DEPTH) begin
         pop1();
         guard++;
      end
   endtask

   task automatic clear_ovf();
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      ovf_m   = 1'b0;
      chk("ovf_clr", 32'(overflow), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int pre;
      resetn    = 1'b0;
      rx_ready  = 1'b1;
      rx_data   = 8'h99;
      rd_strobe = 1'b0;
      ovf_clr   = 1'b0;

      // Reset holds off the handshake even with a byte pending.
      repeat (3) step();
      chk("rst_rx_ack", 32'(rx_ack), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_not_empty", 32'(not_empty), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_wmark", 32'(wmark), 0);
      resetn = 1'b1;
      n = 0;
      while (!rx_ack && n < 8) begin
         step();
         n++;
      end
      chk("rst_ack_after_release", 32'(n >= 1 && n <= 2), 1);
      chk("push_latency_not_empty", 32'(not_empty), 1);
      q.push_back(8'h99);
      rx_ready = 1'b0;
      step();
      step();
      chk_status(1'b0);
      drain();

      // Three-byte ordered push/pop.
      send(8'h41, 1'b0, 1'b0);
      send(8'h42, 1'b0, 1'b0);
      send(8'h43, 1'b0, 1'b0);
      drain();
      chk("empty_after_pops", 32'(not_empty), 0);

      // Overfill by one; the drop is acked and clr in the drop cycle loses to set.
      acks = 0;
      for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0);
      send(8'h10, 1'b0, 1'b1);
      chk("acks_17", acks, 17);
      chk("ovf_sticky", 32'(overflow), 1);
      drain();
      clear_ovf();

      // Full with a coinciding pop: push accepted, pointers wrap over 40 bytes.
      for (int i = 0; i < 16; i++) send(8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         send(8'($urandom), 1'b1, 1'b0);
         chk("full_pop_count", 32'(count), DEPTH);
      end
      chk("full_pop_no_ovf", 32'(overflow), 0);
      drain();

      // Pop on empty is ignored.
      pop1();
      pop1();
      send(8'h5A, 1'b0, 1'b0);
      chk("after_empty_pop", 32'(rd_data), 32'h5A);
      drain();

      // Watermark edges.
      for (int i = 0; i < 11; i++) send(8'(i + 8'h20), 1'b0, 1'b0);
      chk("wmark_below", 32'(wmark), 0);
      send(8'h2B, 1'b0, 1'b0);
      chk("wmark_at", 32'(wmark), 32'(WmEn));
      pop1();
      step();
      chk("wmark_drop", 32'(wmark), 0);
      drain();

      // Random mix of pushes, pops and clears.
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 4))
            0, 1, 2: send(8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            3: pop1();
            default: begin
               pre = q.size();
               ovf_clr = 1'b1;
               step();
               ovf_clr = 1'b0;
               ovf_m   = 1'b0;
               chk_status(WmEn && pre >= WMARK);
            end
         endcase
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
